// File: rtl/issue_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : issue_dispatcher
// Description : In-order issue stage. Accepts one packed instruction bundle
//               at a time from the instruction buffer and presents each
//               valid slot to its own execution lane. A slot is presented
//               once all three of the following hold:
//                 - its operands and rd are free in a 32-entry
//                   pending-destination scoreboard;
//                 - no older pending slot of the same bundle writes one of
//                   its registers;
//                 - every older pending slot fires in the same cycle.
//               Lane writebacks clear scoreboard entries.
// Ports       : clk_i, rst_ni        - clock, async active-low reset
//               bundle_*_i / bundle_ready_o - bundle handshake and contents
//               lane_*_o / lane_ready_i     - per-lane issue handshake
//               wb_valid_i, wb_rd_addr_i    - per-lane writeback
//               flush_i              - drop the held bundle
//               busy_o               - a bundle is being dispatched
//               scoreboard_o         - pending destination register bits
//               stall_cycles_o       - saturating count of no-issue cycles
// Revision    : 1.0 - initial release
// ============================================================================
module issue_dispatcher #(
  parameter int ISSUE_WIDTH = 4,
  parameter int INSTR_WIDTH = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             bundle_valid_i,
  input  logic [ISSUE_WIDTH-1:0]           bundle_mask_i,
  input  logic [ISSUE_WIDTH*INSTR_WIDTH-1:0] bundle_instr_i,
  input  logic [ISSUE_WIDTH*5-1:0]         bundle_rs1_addr_i,
  input  logic [ISSUE_WIDTH*5-1:0]         bundle_rs2_addr_i,
  input  logic [ISSUE_WIDTH*5-1:0]         bundle_rd_addr_i,
  output logic                             bundle_ready_o,
  output logic [ISSUE_WIDTH-1:0]           lane_valid_o,
  output logic [ISSUE_WIDTH*INSTR_WIDTH-1:0] lane_instr_o,
  output logic [ISSUE_WIDTH*5-1:0]         lane_rd_addr_o,
  input  logic [ISSUE_WIDTH-1:0]           lane_ready_i,
  input  logic [ISSUE_WIDTH-1:0]           wb_valid_i,
  input  logic [ISSUE_WIDTH*5-1:0]         wb_rd_addr_i,
  input  logic                             flush_i,
  output logic                             busy_o,
  output logic [31:0]                      scoreboard_o,
  output logic [STALL_CNT_W-1:0]           stall_cycles_o
);

  localparam logic [STALL_CNT_W-1:0] C_STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_DISPATCH = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ISSUE_WIDTH-1:0] r_pending;
  logic [INSTR_WIDTH-1:0] r_instr [ISSUE_WIDTH];
  logic [4:0]             r_rs1   [ISSUE_WIDTH];
  logic [4:0]             r_rs2   [ISSUE_WIDTH];
  logic [4:0]             r_rd    [ISSUE_WIDTH];
  logic [31:0]            r_sb;
  logic [STALL_CNT_W-1:0] r_stall;

  logic [ISSUE_WIDTH-1:0] w_elig;
  logic [ISSUE_WIDTH-1:0] w_fire;
  logic [ISSUE_WIDTH-1:0] w_pending_left;
  logic [31:0]            w_sb_set;
  logic [31:0]            w_sb_clr;
  logic                   w_accept;

  // Eligibility is evaluated from slot 0 upward so that slot i can see
  // whether every older pending slot fires this cycle.
  always_comb begin : p_elig
    logic ok;
    w_elig = '0;
    w_fire = '0;
    ok     = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      ok = r_pending[i] && !flush_i;
      if (r_rs1[i] != 5'd0 && r_sb[r_rs1[i]]) ok = 1'b0;
      if (r_rs2[i] != 5'd0 && r_sb[r_rs2[i]]) ok = 1'b0;
      if (r_rd[i]  != 5'd0 && r_sb[r_rd[i]])  ok = 1'b0;
      for (int j = 0; j < i; j++) begin
        // An older slot's rd blocks even if that slot fires now: the
        // scoreboard is registered, so there is no same-cycle forwarding.
        if (r_pending[j] && r_rd[j] != 5'd0 &&
            (r_rd[j] == r_rs1[i] || r_rd[j] == r_rs2[i] || r_rd[j] == r_rd[i]))
          ok = 1'b0;
        if (r_pending[j] && !w_fire[j]) ok = 1'b0;
      end
      w_elig[i] = ok;
      w_fire[i] = ok && lane_ready_i[i];
    end
  end

  assign w_pending_left = r_pending & ~w_fire;
  assign w_accept       = (r_state == S_IDLE) && bundle_valid_i && !flush_i;

  always_comb begin : p_sb_upd
    w_sb_set = '0;
    w_sb_clr = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (w_fire[i] && r_rd[i] != 5'd0) w_sb_set[r_rd[i]] = 1'b1;
      if (wb_valid_i[i] && wb_rd_addr_i[i*5 +: 5] != 5'd0)
        w_sb_clr[wb_rd_addr_i[i*5 +: 5]] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt    = r_state;
    bundle_ready_o = 1'b0;
    busy_o         = 1'b0;
    case (r_state)
      S_IDLE: begin
        bundle_ready_o = !flush_i;
        if (w_accept && (bundle_mask_i != '0)) w_state_nxt = S_DISPATCH;
      end
      S_DISPATCH: begin
        busy_o = 1'b1;
        if (flush_i || (w_pending_left == '0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Held bundle and pending mask
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        r_instr[i] <= '0;
        r_rs1[i]   <= '0;
        r_rs2[i]   <= '0;
        r_rd[i]    <= '0;
      end
    end else if (w_accept) begin
      r_pending <= bundle_mask_i;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        r_instr[i] <= bundle_instr_i[i*INSTR_WIDTH +: INSTR_WIDTH];
        r_rs1[i]   <= bundle_rs1_addr_i[i*5 +: 5];
        r_rs2[i]   <= bundle_rs2_addr_i[i*5 +: 5];
        r_rd[i]    <= bundle_rd_addr_i[i*5 +: 5];
      end
    end else if (flush_i) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_left;
    end
  end

  // Scoreboard: a set from a firing slot overrides a same-cycle writeback clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sb <= '0;
    else         r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_stall <= '0;
    else if (r_state == S_DISPATCH && w_fire == '0 && r_stall != '1)
      r_stall <= r_stall + C_STALL_ONE;
  end

  always_comb begin
    lane_instr_o   = '0;
    lane_rd_addr_o = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (r_pending[i]) begin
        lane_instr_o[i*INSTR_WIDTH +: INSTR_WIDTH] = r_instr[i];
        lane_rd_addr_o[i*5 +: 5]                   = r_rd[i];
      end
    end
  end

  assign lane_valid_o   = w_elig;
  assign scoreboard_o   = r_sb;
  assign stall_cycles_o = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_issue_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_dispatcher
// Description : Directed self-checking bench for issue_dispatcher. Expected
//               lane issues are queued when a bundle is offered and popped
//               in issue order whenever a lane handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_dispatcher;

  localparam int IW = 4;
  localparam int XW = 32;
  localparam int SW = 4;

  logic            clk;
  logic            rst_n;
  logic            bundle_valid;
  logic [IW-1:0]   bundle_mask;
  logic [IW*XW-1:0] bundle_instr;
  logic [IW*5-1:0] bundle_rs1;
  logic [IW*5-1:0] bundle_rs2;
  logic [IW*5-1:0] bundle_rd;
  logic            bundle_ready;
  logic [IW-1:0]   lane_valid;
  logic [IW*XW-1:0] lane_instr;
  logic [IW*5-1:0] lane_rd;
  logic [IW-1:0]   lane_ready;
  logic [IW-1:0]   wb_valid;
  logic [IW*5-1:0] wb_rd;
  logic            flush;
  logic            busy;
  logic [31:0]     scoreboard;
  logic [SW-1:0]   stall_cycles;

  typedef struct {
    int          lane;
    logic [31:0] instr;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  issue_dispatcher #(.ISSUE_WIDTH(IW), .INSTR_WIDTH(XW), .STALL_CNT_W(SW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .bundle_valid_i   (bundle_valid),
    .bundle_mask_i    (bundle_mask),
    .bundle_instr_i   (bundle_instr),
    .bundle_rs1_addr_i(bundle_rs1),
    .bundle_rs2_addr_i(bundle_rs2),
    .bundle_rd_addr_i (bundle_rd),
    .bundle_ready_o   (bundle_ready),
    .lane_valid_o     (lane_valid),
    .lane_instr_o     (lane_instr),
    .lane_rd_addr_o   (lane_rd),
    .lane_ready_i     (lane_ready),
    .wb_valid_i       (wb_valid),
    .wb_rd_addr_i     (wb_rd),
    .flush_i          (flush),
    .busy_o           (busy),
    .scoreboard_o     (scoreboard),
    .stall_cycles_o   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compare every lane handshake about to complete against the queue.
  task automatic monitor();
    exp_t e;
    for (int l = 0; l < IW; l++) begin
      if (lane_valid[l] && lane_ready[l]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 64'(l), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("issue_lane",  64'(l),                 64'(e.lane));
          chk("issue_instr", 64'(lane_instr[l*XW +: XW]), 64'(e.instr));
          chk("issue_rd",    64'(lane_rd[l*5 +: 5]),  64'(e.rd));
        end
      end
    end
  endtask

  // Called at a falling edge with inputs set; ends at the next falling edge.
  task automatic tick();
    #1;
    monitor();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_slot(input int i, input logic [31:0] ins,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    bundle_instr[i*XW +: XW] = ins;
    bundle_rs1[i*5 +: 5]     = s1;
    bundle_rs2[i*5 +: 5]     = s2;
    bundle_rd[i*5 +: 5]      = d;
  endtask

  // Offer the staged bundle for one cycle and queue its expected issues.
  task automatic offer(input logic [IW-1:0] mask);
    exp_t e;
    bundle_mask  = mask;
    bundle_valid = 1'b1;
    for (int i = 0; i < IW; i++) begin
      if (mask[i]) begin
        e.lane  = i;
        e.instr = bundle_instr[i*XW +: XW];
        e.rd    = bundle_rd[i*5 +: 5];
        exp_q.push_back(e);
      end
    end
    tick();
    bundle_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bundle_valid = 1'b0;
    bundle_mask  = '0;
    bundle_instr = '0;
    bundle_rs1   = '0;
    bundle_rs2   = '0;
    bundle_rd    = '0;
    lane_ready   = '0;
    wb_valid     = '0;
    wb_rd        = '0;
    flush        = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("rst_ready", 64'(bundle_ready), 64'd1);
    chk("rst_valid", 64'(lane_valid), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_sb",    64'(scoreboard), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_instr", 64'(lane_instr[31:0]), 64'd0);

    // ---------------- independent bundle ----------------
    for (int i = 0; i < IW; i++) set_slot(i, 32'hA000_0000 + 32'(i), 5'(10 + i), 5'(20 + i), 5'(1 + i));
    lane_ready = 4'b1111;
    offer(4'b1111);
    chk("ind_valid", 64'(lane_valid), 64'hF);
    chk("ind_busy",  64'(busy), 64'd1);
    chk("ind_ready", 64'(bundle_ready), 64'd0);
    tick();
    chk("ind_sb",    64'(scoreboard), 64'h1E);
    chk("ind_idle",  64'(busy), 64'd0);
    chk("ind_rdy2",  64'(bundle_ready), 64'd1);
    chk("ind_stall", 64'(stall_cycles), 64'd0);

    // ---------------- intra-bundle RAW ----------------
    do_reset();
    set_slot(0, 32'hB000_0000, 5'd10, 5'd11, 5'd5);
    set_slot(1, 32'hB000_0001, 5'd5,  5'd12, 5'd6);
    lane_ready = 4'b1111;
    offer(4'b0011);
    chk("raw_c1_valid", 64'(lane_valid), 64'h1);
    tick();
    chk("raw_c2_valid", 64'(lane_valid), 64'h0);
    chk("raw_c2_sb",    64'(scoreboard), 64'h20);
    tick();
    chk("raw_stall1",   64'(stall_cycles), 64'd1);
    wb_valid = 4'b0001;
    wb_rd    = 20'd5;
    #1;
    chk("raw_wb_valid", 64'(lane_valid), 64'h0);
    tick();
    wb_valid = '0;
    wb_rd    = '0;
    #1;
    chk("raw_sb_clr",   64'(scoreboard), 64'h0);
    chk("raw_s1_valid", 64'(lane_valid), 64'h2);
    tick();
    chk("raw_sb_end",   64'(scoreboard), 64'h40);
    chk("raw_idle",     64'(busy), 64'd0);
    chk("raw_stall2",   64'(stall_cycles), 64'd2);

    // ---------------- in-order stall ----------------
    do_reset();
    for (int i = 0; i < IW; i++) set_slot(i, 32'hC000_0000 + 32'(i), 5'(10 + i), 5'(20 + i), 5'(1 + i));
    lane_ready = 4'b1101;
    offer(4'b1111);
    chk("ord_valid0", 64'(lane_valid), 64'h3);
    tick();
    chk("ord_valid1", 64'(lane_valid), 64'h2);
    chk("ord_stall0", 64'(stall_cycles), 64'd0);
    tick();
    chk("ord_stall1", 64'(stall_cycles), 64'd1);
    lane_ready = 4'b1111;
    #1;
    chk("ord_release", 64'(lane_valid), 64'hE);
    tick();
    chk("ord_idle",  64'(busy), 64'd0);
    chk("ord_sb",    64'(scoreboard), 64'h1E);
    chk("ord_stall", 64'(stall_cycles), 64'd1);

    // ---------------- x0 and set-vs-clear ----------------
    do_reset();
    set_slot(0, 32'hD000_0000, 5'd0, 5'd0, 5'd0);
    set_slot(1, 32'hD000_0001, 5'd8, 5'd9, 5'd7);
    lane_ready = 4'b1111;
    offer(4'b0011);
    chk("x0_valid", 64'(lane_valid), 64'h3);
    wb_valid = 4'b0100;
    wb_rd    = 20'(7) << 10;
    tick();
    wb_valid = '0;
    wb_rd    = '0;
    #1;
    chk("x0_setwins", 64'(scoreboard), 64'h80);
    chk("x0_idle",    64'(busy), 64'd0);

    // ---------------- flush mid-bundle ----------------
    do_reset();
    for (int i = 0; i < IW; i++) set_slot(i, 32'hE000_0000 + 32'(i), 5'(10 + i), 5'(20 + i), 5'(1 + i));
    lane_ready = 4'b0011;
    offer(4'b1111);
    chk("fl_valid0", 64'(lane_valid), 64'h7);
    tick();
    chk("fl_valid1", 64'(lane_valid), 64'h4);
    chk("fl_sb0",    64'(scoreboard), 64'h06);
    flush = 1'b1;
    #1;
    chk("fl_suppress", 64'(lane_valid), 64'h0);
    exp_q.delete();
    tick();
    flush = 1'b0;
    #1;
    chk("fl_idle",  64'(busy), 64'd0);
    chk("fl_ready", 64'(bundle_ready), 64'd1);
    chk("fl_sb1",   64'(scoreboard), 64'h06);
    // A bundle offered while flush is high must not be taken.
    flush        = 1'b1;
    bundle_valid = 1'b1;
    bundle_mask  = 4'b0001;
    #1;
    chk("fl_noaccept_rdy", 64'(bundle_ready), 64'd0);
    tick();
    flush        = 1'b0;
    bundle_valid = 1'b0;
    #1;
    chk("fl_noaccept_busy", 64'(busy), 64'd0);

    // ---------------- stall saturation and async reset ----------------
    do_reset();
    set_slot(0, 32'hF000_0000, 5'd2, 5'd3, 5'd1);
    lane_ready = 4'b0000;
    offer(4'b0001);
    for (int c = 0; c < 20; c++) tick();
    chk("sat_stall", 64'(stall_cycles), 64'hF);
    chk("sat_valid", 64'(lane_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(bundle_ready), 64'd1);
    chk("arst_valid", 64'(lane_valid), 64'd0);
    chk("arst_busy",  64'(busy), 64'd0);
    chk("arst_stall", 64'(stall_cycles), 64'd0);
    chk("arst_sb",    64'(scoreboard), 64'd0);
    chk("arst_instr", 64'(lane_instr[31:0]), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("end_queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
